// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Memory-side target of the CPU MAR/MBR bus. Accepts a
//               single read or write request, waits WAIT_CYCLES wait
//               states, performs the access on an internal register-array
//               memory, and returns read data with a one-cycle
//               acknowledge. Address 1 holds the first instruction fetched
//               after CPU reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W       address width; memory depth is 2**ADDR_W words
//   DATA_W       word width (opcode + operand)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_req        request strobe, sampled only while idle
//   i_we         1 = write, 0 = read, sampled with i_req
//   i_mar_addr   access address, sampled with i_req
//   i_mbr_wdata  write data, sampled with i_req
//   o_mem_mbr    read data toward MBR, holds last read value
//   o_ack        one-cycle completion pulse
//   o_busy       high while an access is in flight
//   o_err        one-cycle error pulse coincident with o_ack
// Build option:
//   MEM_ADDR0_PROTECT_EN  when defined, address 0 is reserved: writes are
//                         dropped, reads return 0, and both flag o_err.
//                         When undefined, address 0 is ordinary and o_err
//                         is always 0.
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_mar_addr,
  input  logic [DATA_W-1:0] i_mbr_wdata,
  output logic [DATA_W-1:0] o_mem_mbr,
  output logic              o_ack,
  output logic              o_busy,
  output logic              o_err
);

  localparam int         C_DEPTH     = 2 ** ADDR_W;
  localparam bit         C_ZERO_WAIT = (WAIT_CYCLES == 0);
  // Counter preload; the WAIT state counts down to 0 inclusive, so
  // WAIT_CYCLES-1 yields exactly WAIT_CYCLES cycles in WAIT.
  localparam logic [3:0] C_CNT_LOAD  = C_ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

`ifdef MEM_ADDR0_PROTECT_EN
  localparam bit C_ADDR0_PROTECT = 1'b1;
`else
  localparam bit C_ADDR0_PROTECT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [C_DEPTH];

  // Access attributes used on the edge entering RESP. With zero wait
  // states that edge is the acceptance edge, so the live inputs are used
  // instead of the (not yet loaded) latched copies.
  logic                w_enter_resp;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic                w_acc_we;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic                w_protect_hit;
  logic                w_mem_we;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    w_enter_resp = 1'b0;
    w_acc_addr   = addr_q;
    w_acc_we     = we_q;
    w_acc_wdata  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          addr_d  = i_mar_addr;
          we_d    = i_we;
          wdata_d = i_mbr_wdata;
          if (C_ZERO_WAIT) begin
            state_d      = S_RESP;
            w_enter_resp = 1'b1;
            w_acc_addr   = i_mar_addr;
            w_acc_we     = i_we;
            w_acc_wdata  = i_mbr_wdata;
          end else begin
            state_d = S_WAIT;
            cnt_d   = C_CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    w_protect_hit = C_ADDR0_PROTECT && (w_acc_addr == '0);

    if (w_enter_resp) begin
      ack_d = 1'b1;
      err_d = w_protect_hit;
      if (!w_acc_we) begin
        rdata_d = w_protect_hit ? '0 : mem_q[w_acc_addr];
      end
    end

    // A reset on the committing edge abandons the write.
    w_mem_we = w_enter_resp && w_acc_we && !w_protect_hit && !i_rst;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Storage is intentionally not reset so program contents survive a CPU reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      mem_q[w_acc_addr] <= w_acc_wdata;
    end
  end

  assign o_mem_mbr = rdata_q;
  assign o_ack     = ack_q;
  assign o_err     = err_q;
  assign o_busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire
